// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 data mux among four requesters.
// The selected word is captured into a valid/ready output register.
module mux4_rr_arbiter #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] din0,
    input  logic [WIDTH-1:0] din1,
    input  logic [WIDTH-1:0] din2,
    input  logic [WIDTH-1:0] din3,
    output logic [3:0]       gnt,
    output logic [1:0]       sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state;
    logic [1:0]       ptr;
    logic [1:0]       last_sel;
    logic [1:0]       winner;
    logic [1:0]       off;
    logic [7:0]       dbl;
    logic [7:0]       shf;
    logic [3:0]       rot;
    logic             cap_en;
    logic [WIDTH-1:0] mux_data;

    assign out_valid = (state == FULL);

    // Gating with rst_n keeps grants quiet while reset is held.
    assign cap_en = rst_n && (|req) && (!out_valid || out_ready);

    assign dbl = {req, req};
    assign shf = dbl >> ptr;
    assign rot = shf[3:0];

    // First requester at or after ptr in circular order.
    always_comb begin
        off = 2'd0;
        priority case (1'b1)
            rot[0]:  off = 2'd0;
            rot[1]:  off = 2'd1;
            rot[2]:  off = 2'd2;
            rot[3]:  off = 2'd3;
            default: off = 2'd0;
        endcase
    end

    assign winner = ptr + off;
    assign gnt    = cap_en ? (4'b0001 << winner) : 4'b0000;
    assign sel    = cap_en ? winner : last_sel;

    // Shared data mux driven by the current winner.
    always_comb begin
        mux_data = din0;
        unique case (winner)
            2'd0: mux_data = din0;
            2'd1: mux_data = din1;
            2'd2: mux_data = din2;
            2'd3: mux_data = din3;
            default: mux_data = din0;
        endcase
    end

    // Output stage FSM with pointer and last-select tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            out_data <= '0;
            ptr      <= 2'd0;
            last_sel <= 2'd0;
        end else if (cap_en) begin
            state    <= FULL;
            out_data <= mux_data;
            last_sel <= winner;
            ptr      <= winner + 2'd1;
        end else if (out_valid && out_ready) begin
            state    <= EMPTY;
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter.
// Expected words queue up on grant and are checked on acceptance.
module tb_mux4_rr_arbiter;

    localparam int W = 64;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req;
    logic [W-1:0] din0, din1, din2, din3;
    logic [3:0]   gnt;
    logic [1:0]   sel;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    mux4_rr_arbiter #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .din0      (din0),
        .din1      (din1),
        .din2      (din2),
        .din3      (din3),
        .gnt       (gnt),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name,
                       input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic [3:0] r, input logic rdy,
                       input logic [3:0] eg, input logic [1:0] es,
                       input bit push, input logic [W-1:0] ed);
        req = r;
        out_ready = rdy;
        @(negedge clk);
        chk("gnt", W'(gnt), W'(eg));
        chk("sel", W'(sel), W'(es));
        if (push) exp_q.push_back(ed);
        @(posedge clk);
        #1;
    endtask

    task automatic set_din(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] c, input logic [W-1:0] d);
        din0 = a;
        din1 = b;
        din2 = c;
        din3 = d;
    endtask

    // Monitor: every accepted word must match the oldest expected word.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL accept: got %h expected none", out_data);
                end else begin
                    chk("out_data", out_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        req = 4'b1111;
        out_ready = 1'b0;
        set_din('0, '0, '0, '0);

        // Reset holds grants and output low.
        @(negedge clk);
        chk("rst_gnt", W'(gnt), W'(4'b0000));
        chk("rst_valid", W'(out_valid), W'(1'b0));
        chk("rst_data", out_data, '0);
        @(negedge clk);
        req = 4'b0000;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Idle.
        for (int i = 0; i < 5; i++) begin
            cyc(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, '0);
            chk("idle_valid", W'(out_valid), W'(1'b0));
            chk("idle_data", out_data, '0);
        end

        // Single requester 2.
        din2 = 64'hDEAD_BEEF_0000_0002;
        cyc(4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 64'hDEAD_BEEF_0000_0002);
        chk("single_valid", W'(out_valid), W'(1'b1));
        cyc(4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0, '0);

        // Move pointer to 0 through requester 3.
        set_din(64'd1, 64'd2, 64'd3, 64'd4);
        cyc(4'b1000, 1'b1, 4'b1000, 2'd3, 1'b1, 64'd4);

        // Full contention, no backpressure.
        cyc(4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 64'd1);
        cyc(4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, 64'd2);
        cyc(4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1, 64'd3);
        cyc(4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, 64'd4);
        cyc(4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 64'd1);
        cyc(4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, 64'd2);

        // Wrap and skip absent requester 0.
        cyc(4'b1000, 1'b1, 4'b1000, 2'd3, 1'b1, 64'd4);
        cyc(4'b1010, 1'b1, 4'b0010, 2'd1, 1'b1, 64'd2);
        cyc(4'b1010, 1'b1, 4'b1000, 2'd3, 1'b1, 64'd4);
        cyc(4'b1010, 1'b1, 4'b0010, 2'd1, 1'b1, 64'd2);
        cyc(4'b0000, 1'b1, 4'b0000, 2'd1, 1'b0, '0);

        // Backpressure.
        set_din(64'h11, 64'h22, 64'h33, 64'h44);
        cyc(4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1, 64'h11);
        for (int i = 0; i < 4; i++) begin
            cyc(4'b0011, 1'b0, 4'b0000, 2'd0, 1'b0, '0);
            chk("bp_valid", W'(out_valid), W'(1'b1));
            chk("bp_data", out_data, 64'h11);
        end
        cyc(4'b0011, 1'b1, 4'b0010, 2'd1, 1'b1, 64'h22);
        cyc(4'b0000, 1'b1, 4'b0000, 2'd1, 1'b0, '0);

        // Async reset mid-stream.
        set_din(64'd1, 64'd2, 64'd3, 64'd4);
        cyc(4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1, 64'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", W'(out_valid), W'(1'b0));
        chk("arst_data", out_data, '0);
        chk("arst_gnt", W'(gnt), W'(4'b0000));
        exp_q.delete();
        @(negedge clk);
        chk("arst_gnt2", W'(gnt), W'(4'b0000));
        req = 4'b0000;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc(4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 64'd1);
        cyc(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, '0);
        cyc(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, '0);

        chk("end_valid", W'(out_valid), W'(1'b0));
        chk("end_queue", W'(exp_q.size()), W'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 4:1 data mux between four requesters feeding a single downstream consumer, such as an ALU operand port or a writeback bus.
- Picks one requester per transfer, drives the mux select, and captures the selected word into a registered output stage.
- The output stage uses a valid/ready handshake.
- Fairness: a requester granted once will not be granted again while any other requester is waiting.

Parameters:
- WIDTH, 64, data word width in bits. Matches the Y86-64 datapath.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  4  per-requester request; req[i] high means din_i is valid.
- din0  input  WIDTH  requester 0 data.
- din1  input  WIDTH  requester 1 data.
- din2  input  WIDTH  requester 2 data.
- din3  input  WIDTH  requester 3 data.
- gnt  output  4  one-hot grant, combinational. A transfer from requester i occurs on a rising edge where req[i] and gnt[i] are both high.
- sel  output  2  mux select, combinational. Index of the current winner; equals the last winner when there is no capture.
- out_valid  output  1  registered; out_data holds an untaken word.
- out_data  output  WIDTH  registered captured word.
- out_ready  input  1  consumer accepts out_data on an edge where out_valid and out_ready are both high.

Behaviour:
- Reset (rst_n low, async): out_valid=0, out_data=0, ptr=0, last_sel=0. While rst_n is low, gnt=0 regardless of req.
- State: two-state FSM built on out_valid.
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- Capture enable: cap_en = (|req) && (!out_valid || out_ready).
- Winner: the first i in circular order ptr, ptr+1, ptr+2, ptr+3 (mod 4) with req[i]=1. Computed combinationally every cycle.
- gnt = onehot(winner) when cap_en, else 4'b0000. Never more than one bit set.
- sel = winner when cap_en, else last_sel.
- On an edge with cap_en:
  - out_data <= din[winner]
  - out_valid <= 1
  - last_sel <= winner
  - ptr <= (winner+1) mod 4; wraps 3 -> 0.
- On an edge with out_valid && out_ready && !(|req): out_valid <= 0; out_data holds its value.
- Latency: a request at edge k (output EMPTY or being accepted) appears on out_data/out_valid after edge k. Gnt is seen in the same cycle as the request.
- Throughput: with out_ready held at 1, one transfer per cycle.
- Backpressure: while out_valid=1 and out_ready=0:
  - out_data and out_valid hold.
  - gnt=0.
  - ptr does not move.
  - Requesters keep req high; no request is lost.
- Simultaneous accept and capture (out_valid=1, out_ready=1, |req): the old word is consumed and the new word loaded on the same edge. out_valid stays 1 with no bubble.
- Pointer:
  - ptr updates only on a capture.
  - A requester that drops req before it is granted is skipped; no grant is issued to it.
- Requester contract: after a transfer, the requester must update din/req before the next edge if it has no further data. Holding req high means it has another word.
- Reset mid-operation: any word held in the output stage is discarded; the round-robin order restarts at requester 0.
- No X propagation: sel and gnt are fully defined for every req value, including 4'b0000.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, release, req=0000 for 5 cycles -> out_valid=0, out_data=0, gnt=0000, sel=0 throughout.
- Single requester: req=0100, din2=64'hDEAD_BEEF_0000_0002, out_ready=1 -> same cycle gnt=0100, sel=2. Next cycle out_valid=1, out_data=64'hDEAD_BEEF_0000_0002. Ptr becomes 3.
- Full contention with no backpressure: req=1111 held, dinN=N+1, out_ready=1 -> grant order 0,1,2,3,0,1; out_data sequence 1,2,3,4,1,2 on consecutive cycles with no bubbles.
- Wrap and skip: after a grant to 3 (ptr=0), req=1010 -> next grants are 1 then 3, then 1 again (3 -> 0 wrap skips absent requester 0).
- Backpressure: req=0011, out_ready=0 after the first capture of din0=64'h11 -> out_data stays 64'h11 and gnt=0000 for 4 cycles. Raise out_ready -> on that edge 64'h11 is consumed and din1 is loaded; gnt=0010 in that cycle.
- Async reset mid-stream: req=1111, out_ready=1, drop rst_n between clock edges -> out_valid=0 and out_data=0 immediately, without waiting for an edge, and gnt=0000. After release, the first grant goes to requester 0.
